// File: rtl/missile_launcher_if.sv
// Pose, pixel-query and draw signals between the missile launcher and its neighbours.
// master drives ship pose, fire/frame/hit and scan position; slave is the launcher.
interface missile_launcher_if #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int N  = 4
);
    logic               fire;
    logic               frame_pulse;
    logic [XW-1:0]      ship_x;
    logic [YW-1:0]      ship_y;
    logic signed [17:0] sin_val;
    logic signed [17:0] cos_val;
    logic [N-1:0]       hit;
    logic [XW-1:0]      pxl_x;
    logic [YW-1:0]      pxl_y;
    logic [N-1:0]       active;
    logic [N-1:0]       slot_draw;
    logic [3:0]         Red;
    logic [3:0]         Green;
    logic [3:0]         Blue;
    logic               Draw;

    modport master (
        output fire, frame_pulse, ship_x, ship_y,
        output sin_val, cos_val, hit, pxl_x, pxl_y,
        input  active, slot_draw, Red, Green, Blue, Draw
    );

    modport slave (
        input  fire, frame_pulse, ship_x, ship_y,
        input  sin_val, cos_val, hit, pxl_x, pxl_y,
        output active, slot_draw, Red, Green, Blue, Draw
    );
endinterface

// File: rtl/missile_launcher.sv
// Missile launcher: N slots spawned at the ship centre, flown along the heading, drawn as squares.
// MISSILE_WRAP_EN: defined -> off-screen positions wrap; undefined -> off-screen kills the slot.
module missile_launcher #(
    parameter int          WIDTH      = 640,
    parameter int          HEIGHT     = 480,
    parameter int          N_MISSILES = 4,
    parameter int          SPEED      = 6,
    parameter int          LIFE       = 40,
    parameter int          COOLDOWN   = 8,
    parameter int          SIZE       = 3,
    parameter logic [11:0] COLOR      = 12'hFF0
) (
    input logic               clk,
    input logic               resetN,
    missile_launcher_if.slave bus
);
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int N    = N_MISSILES;
    localparam int PXW  = XW + 8;
    localparam int PYW  = YW + 8;
    localparam int SXW  = ((PXW > 18) ? PXW : 18) + 2;
    localparam int SYW  = ((PYW > 18) ? PYW : 18) + 2;
    localparam int HALF = SIZE / 2;

    localparam logic signed [7:0]     SPD    = 8'(SPEED);
    localparam logic [7:0]            LIFE_V = 8'(LIFE);
    localparam logic [7:0]            COOL_V = 8'(COOLDOWN);
    localparam logic signed [SXW-1:0] X_SPAN = SXW'(WIDTH * 256);
    localparam logic signed [SYW-1:0] Y_SPAN = SYW'(HEIGHT * 256);
    localparam logic [XW:0]           HALF_X = (XW + 1)'(HALF);
    localparam logic [YW:0]           HALF_Y = (YW + 1)'(HALF);

    logic               fire_q;
    logic               fire_d;
    logic [7:0]         cooldown_q;
    logic [7:0]         cooldown_d;
    logic [N-1:0]       active_q;
    logic [N-1:0]       active_d;
    logic [PXW-1:0]     pos_x_q [N];
    logic [PXW-1:0]     pos_x_d [N];
    logic [PYW-1:0]     pos_y_q [N];
    logic [PYW-1:0]     pos_y_d [N];
    logic signed [17:0] vel_x_q [N];
    logic signed [17:0] vel_x_d [N];
    logic signed [17:0] vel_y_q [N];
    logic signed [17:0] vel_y_d [N];
    logic [7:0]         life_q  [N];
    logic [7:0]         life_d  [N];

    logic [N-1:0]       slot_draw_q;
    logic [N-1:0]       slot_draw_d;
    logic               draw_q;
    logic               draw_d;
    logic [11:0]        rgb_q;
    logic [11:0]        rgb_d;

    logic               fire_edge;
    logic               launch;
    logic [N-1:0]       launch_oh;
    logic signed [25:0] prod_x;
    logic signed [25:0] prod_y;
    logic signed [17:0] vel_x_new;
    logic signed [17:0] vel_y_new;

    // Accept a fire edge into the lowest free slot; scale heading into a velocity
    always_comb begin
        fire_edge = bus.fire & ~fire_q;
        launch_oh = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                launch_oh    = '0;
                launch_oh[i] = 1'b1;
            end
        end
        if (!fire_edge || (cooldown_q != 8'd0)) begin
            launch_oh = '0;
        end
        launch    = |launch_oh;
        prod_x    = 26'(bus.cos_val) * 26'(SPD);
        prod_y    = 26'(bus.sin_val) * 26'(SPD);
        vel_x_new = prod_x[25:8];
        vel_y_new = -prod_y[25:8];
    end

    // Slot update: launch beats hit, hit beats the frame move
    always_comb begin
        logic signed [SXW-1:0] sum_x;
        logic signed [SYW-1:0] sum_y;
        logic                  off_x;
        logic                  off_y;

        fire_d     = bus.fire;
        cooldown_d = cooldown_q;
        active_d   = active_q;
        sum_x      = '0;
        sum_y      = '0;
        off_x      = 1'b0;
        off_y      = 1'b0;

        if (launch) begin
            cooldown_d = COOL_V;
        end else if (bus.frame_pulse && (cooldown_q != 8'd0)) begin
            cooldown_d = cooldown_q - 8'd1;
        end

        for (int i = 0; i < N; i++) begin
            pos_x_d[i] = pos_x_q[i];
            pos_y_d[i] = pos_y_q[i];
            vel_x_d[i] = vel_x_q[i];
            vel_y_d[i] = vel_y_q[i];
            life_d[i]  = life_q[i];

            sum_x = {{(SXW - PXW){1'b0}}, pos_x_q[i]}
                  + {{(SXW - 18){vel_x_q[i][17]}}, vel_x_q[i]};
            sum_y = {{(SYW - PYW){1'b0}}, pos_y_q[i]}
                  + {{(SYW - 18){vel_y_q[i][17]}}, vel_y_q[i]};
            off_x = 1'b0;
            off_y = 1'b0;
`ifdef MISSILE_WRAP_EN
            if (sum_x[SXW-1]) begin
                sum_x = sum_x + X_SPAN;
            end else if (sum_x >= X_SPAN) begin
                sum_x = sum_x - X_SPAN;
            end
            if (sum_y[SYW-1]) begin
                sum_y = sum_y + Y_SPAN;
            end else if (sum_y >= Y_SPAN) begin
                sum_y = sum_y - Y_SPAN;
            end
`else
            off_x = sum_x[SXW-1] || (sum_x >= X_SPAN);
            off_y = sum_y[SYW-1] || (sum_y >= Y_SPAN);
`endif

            if (launch_oh[i]) begin
                pos_x_d[i]  = {bus.ship_x, 8'h80};
                pos_y_d[i]  = {bus.ship_y, 8'h80};
                vel_x_d[i]  = vel_x_new;
                vel_y_d[i]  = vel_y_new;
                life_d[i]   = LIFE_V;
                active_d[i] = 1'b1;
            end else if (active_q[i] && bus.hit[i]) begin
                active_d[i] = 1'b0;
            end else if (active_q[i] && bus.frame_pulse) begin
                pos_x_d[i] = sum_x[PXW-1:0];
                pos_y_d[i] = sum_y[PYW-1:0];
                life_d[i]  = life_q[i] - 8'd1;
                if ((life_q[i] == 8'd1) || off_x || off_y) begin
                    active_d[i] = 1'b0;
                end
            end
        end
    end

    // Square coverage test per live slot, merged into a single colour
    always_comb begin
        logic [XW:0] dx;
        logic [XW:0] ax;
        logic [YW:0] dy;
        logic [YW:0] ay;

        dx = '0;
        ax = '0;
        dy = '0;
        ay = '0;
        slot_draw_d = '0;
        for (int i = 0; i < N; i++) begin
            dx = {1'b0, bus.pxl_x} - {1'b0, pos_x_q[i][PXW-1:8]};
            dy = {1'b0, bus.pxl_y} - {1'b0, pos_y_q[i][PYW-1:8]};
            ax = dx[XW] ? -dx : dx;
            ay = dy[YW] ? -dy : dy;
            slot_draw_d[i] = active_q[i] && (ax <= HALF_X) && (ay <= HALF_Y);
        end
        draw_d = |slot_draw_d;
        rgb_d  = draw_d ? COLOR : 12'h000;
    end

    // Fire edge detector, cooldown and slot state registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_q     <= 1'b0;
            cooldown_q <= 8'd0;
            active_q   <= '0;
            for (int i = 0; i < N; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
                life_q[i]  <= '0;
            end
        end else begin
            fire_q     <= fire_d;
            cooldown_q <= cooldown_d;
            active_q   <= active_d;
            for (int i = 0; i < N; i++) begin
                pos_x_q[i] <= pos_x_d[i];
                pos_y_q[i] <= pos_y_d[i];
                vel_x_q[i] <= vel_x_d[i];
                vel_y_q[i] <= vel_y_d[i];
                life_q[i]  <= life_d[i];
            end
        end
    end

    // One-cycle registered pixel outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_draw_q <= '0;
            draw_q      <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            slot_draw_q <= slot_draw_d;
            draw_q      <= draw_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.active    = active_q;
    assign bus.slot_draw = slot_draw_q;
    assign bus.Draw      = draw_q;
    assign bus.Red       = rgb_q[11:8];
    assign bus.Green     = rgb_q[7:4];
    assign bus.Blue      = rgb_q[3:0];
endmodule
